// File: rtl/hssl_cfg_pkt_rx.sv
`default_nettype none
// ============================================================================
//  Module      : hssl_cfg_pkt_rx
//  Description : SpiNNaker packet receiver front-end. Packets whose key matches
//                CFG_KEY under CFG_MSK and carry a payload become one-cycle
//                register writes. Config packets without payload are dropped
//                and flagged. All other packets are forwarded through a
//                2-entry FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module hssl_cfg_pkt_rx #(
    parameter logic [31:0] CFG_KEY = 32'hffff_fe00,
    parameter logic [31:0] CFG_MSK = 32'hffff_ff00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pkt_key_in,
    input  logic [31:0] pkt_data_in,
    input  logic        pkt_pld_in,
    input  logic        pkt_vld_in,
    output logic        pkt_rdy_out,
    output logic [7:0]  prx_addr_out,
    output logic [31:0] prx_wdata_out,
    output logic        prx_en_out,
    output logic        cfg_bad_out,
    output logic [31:0] out_key_out,
    output logic [31:0] out_data_out,
    output logic        out_pld_out,
    output logic        out_vld_out,
    input  logic        out_rdy_in
);

    localparam logic [1:0] c_CNT_FULL = 2'd2;

    // FIFO storage and bookkeeping
    logic [1:0]  r_count;
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [31:0] r_key_mem  [2];
    logic [31:0] r_data_mem [2];
    logic [1:0]  r_pld_mem;

    // Register-write interface
    logic        r_prx_en;
    logic [7:0]  r_prx_addr;
    logic [31:0] r_prx_wdata;
    logic        r_cfg_bad;

    logic        w_rdy;
    logic        w_accept;
    logic        w_is_cfg;
    logic        w_push;
    logic        w_pop;
    logic        w_cfg_wr;
    logic        w_cfg_drop;

    // Ready is taken from the count register alone so it never depends on
    // the packet being offered.
    assign w_rdy      = (r_count != c_CNT_FULL);
    assign w_accept   = pkt_vld_in && w_rdy;
    assign w_is_cfg   = ((pkt_key_in & CFG_MSK) == (CFG_KEY & CFG_MSK));
    assign w_cfg_wr   = w_accept && w_is_cfg && pkt_pld_in;
    assign w_cfg_drop = w_accept && w_is_cfg && !pkt_pld_in;
    assign w_push     = w_accept && !w_is_cfg;
    assign w_pop      = (r_count != 2'd0) && out_rdy_in;

    // Config packets turn into a registered write strobe one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prx_en    <= 1'b0;
            r_prx_addr  <= 8'd0;
            r_prx_wdata <= 32'd0;
            r_cfg_bad   <= 1'b0;
        end else begin
            r_prx_en  <= w_cfg_wr;
            r_cfg_bad <= w_cfg_drop;
            if (w_cfg_wr) begin
                r_prx_addr  <= pkt_key_in[7:0];
                r_prx_wdata <= pkt_data_in;
            end
        end
    end

    // Two-entry FIFO for forwarded packets; storage is cleared on reset so
    // the output fields read zero while empty after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count   <= 2'd0;
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
            r_pld_mem <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                r_key_mem[i]  <= 32'd0;
                r_data_mem[i] <= 32'd0;
            end
        end else begin
            if (w_push) begin
                r_key_mem[r_wr_ptr]  <= pkt_key_in;
                r_data_mem[r_wr_ptr] <= pkt_data_in;
                r_pld_mem[r_wr_ptr]  <= pkt_pld_in;
                r_wr_ptr             <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign pkt_rdy_out   = w_rdy;
    assign prx_en_out    = r_prx_en;
    assign prx_addr_out  = r_prx_addr;
    assign prx_wdata_out = r_prx_wdata;
    assign cfg_bad_out   = r_cfg_bad;
    assign out_vld_out   = (r_count != 2'd0);
    assign out_key_out   = r_key_mem[r_rd_ptr];
    assign out_data_out  = r_data_mem[r_rd_ptr];
    assign out_pld_out   = r_pld_mem[r_rd_ptr];

endmodule
`default_nettype wire
